// File: rtl/clock_phase_gen.sv
// Multi-channel clock generator: pass, invert, divided and divided-inverted outputs
// derived from one source clock, with glitch-free ratio/mode updates at period boundaries.
module clock_phase_gen #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 4,
    parameter int DEFAULT_HALF = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CNT_W-1:0]    div_half,
    input  logic                div_load,
    input  logic [2*NUM_CH-1:0] mode,
    output logic [NUM_CH-1:0]   clk_out,
    output logic                phase_tick,
    output logic                locked
);

    typedef enum logic [1:0] {
        MODE_PASS    = 2'b00,
        MODE_INV     = 2'b01,
        MODE_DIV     = 2'b10,
        MODE_DIV_INV = 2'b11
    } ch_mode_e;

    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                div_q, div_d;
    logic [CNT_W-1:0]    active_half_q, active_half_d;
    logic [CNT_W-1:0]    shadow_half_q, shadow_half_d;
    logic                pending_q, pending_d;
    logic [2*NUM_CH-1:0] mode_q, mode_d;
    logic                phase_tick_q, phase_tick_d;
    logic                locked_q, locked_d;

    logic [CNT_W-1:0]    eff_half;
    logic                terminal;
    logic                period_bound;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        eff_half      = (active_half_q == '0) ? CNT_W'(1) : active_half_q;
        terminal      = (cnt_q == eff_half - CNT_W'(1));
        period_bound  = terminal && div_q;

        cnt_d         = terminal ? '0 : cnt_q + CNT_W'(1);
        div_d         = div_q ^ terminal;
        phase_tick_d  = terminal && !div_q;
        active_half_d = active_half_q;
        shadow_half_d = shadow_half_q;
        pending_d     = pending_q;
        mode_d        = mode_q;
        locked_d      = locked_q;

        // Reconfiguration only as div_q falls, so the next period starts clean.
        if (period_bound) begin
            mode_d   = mode;
            locked_d = !pending_q;
            if (pending_q) begin
                active_half_d = shadow_half_q;
                pending_d     = 1'b0;
            end
        end

        // A load on the boundary cycle is evaluated after the apply, so it waits for the next one.
        if (div_load) begin
            shadow_half_d = div_half;
            pending_d     = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            div_q         <= 1'b0;
            active_half_q <= RST_HALF;
            shadow_half_q <= RST_HALF;
            pending_q     <= 1'b0;
            mode_q        <= '0;
            phase_tick_q  <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            active_half_q <= active_half_d;
            shadow_half_q <= shadow_half_d;
            pending_q     <= pending_d;
            mode_q        <= mode_d;
            phase_tick_q  <= phase_tick_d;
            locked_q      <= locked_d;
        end
    end

    // Reset gates every channel low, including the combinational pass/invert paths.
    always_comb begin
        clk_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (ch_mode_e'(mode_q[2*i +: 2]))
                MODE_PASS:    clk_out[i] = clock;
                MODE_INV:     clk_out[i] = ~clock;
                MODE_DIV:     clk_out[i] = div_q;
                MODE_DIV_INV: clk_out[i] = ~div_q;
            endcase
        end
        if (reset) begin
            clk_out = '0;
        end
    end

    assign phase_tick = phase_tick_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Randomised bench for clock_phase_gen: a period-position model predicts every output
// on both clock phases, with directed scenarios followed by random loads, modes and resets.
module tb_clock_phase_gen;

    localparam int NUM_CH       = 4;
    localparam int CNT_W        = 4;
    localparam int DEFAULT_HALF = 1;

    logic                clock;
    logic                reset;
    logic [CNT_W-1:0]    div_half;
    logic                div_load;
    logic [2*NUM_CH-1:0] mode;
    logic [NUM_CH-1:0]   clk_out;
    logic                phase_tick;
    logic                locked;

    clock_phase_gen #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .DEFAULT_HALF(DEFAULT_HALF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .div_half(div_half),
        .div_load(div_load),
        .mode(mode),
        .clk_out(clk_out),
        .phase_tick(phase_tick),
        .locked(locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: position within the current divided period (0 .. 2*half-1).
    int                  m_half;
    int                  m_shadow;
    int                  m_pos;
    bit                  m_pending;
    bit                  m_locked;
    bit                  m_tick;
    logic [2*NUM_CH-1:0] m_mode;

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    function automatic bit m_div();
        return m_pos >= eff(m_half);
    endfunction

    function automatic void model_reset();
        m_half    = DEFAULT_HALF;
        m_shadow  = DEFAULT_HALF;
        m_pos     = 0;
        m_pending = 0;
        m_locked  = 0;
        m_tick    = 0;
        m_mode    = '0;
    endfunction

    function automatic void model_edge(input bit ld, input int dh, input logic [2*NUM_CH-1:0] md);
        int h;
        h      = eff(m_half);
        m_tick = 0;
        if (m_pos == 2*h - 1) begin
            m_pos  = 0;
            m_mode = md;
            if (m_pending) begin
                m_half    = m_shadow;
                m_pending = 0;
                m_locked  = 0;
            end else begin
                m_locked = 1;
            end
        end else begin
            m_pos++;
            m_tick = (m_pos == h);
        end
        if (ld) begin
            m_shadow  = dh;
            m_pending = 1;
        end
    endfunction

    function automatic logic [NUM_CH-1:0] exp_clk(input logic lvl);
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) begin
            case (m_mode[2*i +: 2])
                2'b00:   r[i] = lvl;
                2'b01:   r[i] = ~lvl;
                2'b10:   r[i] = m_div();
                default: r[i] = ~m_div();
            endcase
        end
        return r;
    endfunction

    // Called at a falling edge; drives inputs, then checks after the rise and at the next fall.
    task automatic cycle(input logic ld, input logic [CNT_W-1:0] dh, input logic [2*NUM_CH-1:0] md);
        div_load = ld;
        div_half = dh;
        mode     = md;
        @(posedge clock);
        model_edge(ld, int'(dh), md);
        #1;
        check("clk_hi", 32'(clk_out), 32'(exp_clk(1'b1)));
        check("tick", 32'(phase_tick), 32'(m_tick));
        check("locked", 32'(locked), 32'(m_locked));
        @(negedge clock);
        check("clk_lo", 32'(clk_out), 32'(exp_clk(1'b0)));
        div_load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, div_half, mode);
    endtask

    // Reset asserted while the source clock is high; outputs must drop at once.
    task automatic async_reset();
        div_load = 1'b0;
        @(posedge clock);
        model_edge(1'b0, int'(div_half), mode);
        #2;
        reset = 1'b1;
        #1;
        check("rst_clk", 32'(clk_out), 32'h0);
        check("rst_lock", 32'(locked), 32'h0);
        check("rst_tick", 32'(phase_tick), 32'h0);
        model_reset();
        @(negedge clock);
        @(posedge clock);
        #1;
        check("rst_hold_clk", 32'(clk_out), 32'h0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [2*NUM_CH-1:0] md;
        reset    = 1'b1;
        div_load = 1'b0;
        div_half = '0;
        mode     = 8'hAA;
        model_reset();

        @(posedge clock);
        #1;
        check("init_clk", 32'(clk_out), 32'h0);
        check("init_lock", 32'(locked), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Divide-by-2 from reset; locked after the first boundary.
        cycle(1'b0, 4'd0, 8'hAA);
        check("first_tick", 32'(phase_tick), 32'h1);
        cycle(1'b0, 4'd0, 8'hAA);
        check("first_lock", 32'(locked), 32'h1);
        idle(3);

        // Ratio 3 loaded mid-period.
        cycle(1'b1, 4'd3, 8'hAA);
        idle(20);

        // Ratio 0 behaves as 1.
        cycle(1'b1, 4'd0, 8'hAA);
        idle(10);

        // Ratio 2, then channel 0 switched to divided-inverted.
        cycle(1'b1, 4'd2, 8'hAA);
        idle(8);
        cycle(1'b0, 4'd2, 8'hA8);
        idle(4);
        cycle(1'b0, 4'd2, 8'hAB);
        idle(12);

        // Two loads in one period: last value wins.
        cycle(1'b1, 4'd5, 8'hAB);
        cycle(1'b1, 4'd2, 8'hAB);
        idle(14);

        // Largest ratio, then ratio 4 and reset during the high phase.
        cycle(1'b1, 4'd15, 8'h1B);
        idle(70);
        cycle(1'b1, 4'd4, 8'hAA);
        idle(40);
        for (int k = 0; k < 40 && !m_div(); k++) idle(1);
        check("div_high_before_rst", 32'(m_div()), 32'h1);
        async_reset();
        idle(6);

        // Random loads, mode changes and occasional resets.
        md = 8'hAA;
        for (int n = 0; n < 2500; n++) begin
            logic             ld;
            logic [CNT_W-1:0] dh;
            if ($urandom_range(0, 9) == 0) md = 8'($urandom);
            ld = ($urandom_range(0, 11) == 0);
            dh = ($urandom_range(0, 3) != 0) ? CNT_W'($urandom_range(0, 4))
                                             : CNT_W'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                mode = md;
                async_reset();
            end else begin
                cycle(ld, dh, md);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
